// File: rtl/i2s_tx_controller.sv
// I2S transmit controller: derives BCLK/LRCLK from one divider chain, takes
// stereo pairs over valid/ready and shifts them out MSB-first with the
// standard one-bit delay after each LRCLK edge.
module i2s_tx_controller #(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              busy,
    output logic              underflow
);

    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [BIT_W-1:0] BitLast = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SlotW   = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] DataW   = BIT_W'(DATA_W);
    localparam logic [DIV_W-1:0] DivLast = DIV_W'(BCLK_DIV - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bit_q;
    logic              bclk_q, lrclk_q, sdata_q, underflow_q, s_ready_q;
    // Set until the first falling event of a run, which must land on bit 0.
    logic              first_q;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_left_q, hold_right_q;
    logic [DATA_W-1:0] frame_right_q;
    logic [DATA_W-1:0] shift_q;

    logic              div_wrap, fall_evt, frame_edge, stop_now, frame_start, accept;
    logic [BIT_W-1:0]  bit_new, slot_k;

    assign div_wrap    = (state_q == StRun) && (div_q == DivLast);
    assign fall_evt    = div_wrap && bclk_q;
    assign bit_new     = (first_q || (bit_q == BitLast)) ? '0 : bit_q + 1'b1;
    assign frame_edge  = fall_evt && (bit_new == '0);
    assign stop_now    = frame_edge && !enable;
    assign frame_start = frame_edge && enable;
    assign slot_k      = (bit_new >= SlotW) ? bit_new - SlotW : bit_new;
    assign accept      = s_valid && s_ready_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic: a stop only takes effect on a frame boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable)   state_d = StRun;
            StRun:  if (stop_now) state_d = StIdle;
            default:              state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q == StRun);
        bclk      = bclk_q;
        lrclk     = lrclk_q;
        sdata     = sdata_q;
        underflow = underflow_q;
        s_ready   = s_ready_q;
    end

    // BCLK divider: toggles bclk every BCLK_DIV clk while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if ((state_q != StRun) || stop_now) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (div_wrap) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    // Bit counter, word select and serializer, all updated on bclk falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q         <= '0;
            first_q       <= 1'b1;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            shift_q       <= '0;
            frame_right_q <= '0;
        end else if ((state_q != StRun) || stop_now) begin
            bit_q   <= '0;
            first_q <= 1'b1;
            lrclk_q <= 1'b1;
            sdata_q <= 1'b0;
        end else if (fall_evt) begin
            bit_q   <= bit_new;
            first_q <= 1'b0;
            lrclk_q <= (bit_new >= SlotW);
            if (frame_start) begin
                frame_right_q <= hold_full_q ? hold_right_q : '0;
            end
            if (slot_k == '0) begin
                // Delay bit; preload the channel that the following bits carry
                sdata_q <= 1'b0;
                if (frame_start) shift_q <= hold_full_q ? hold_left_q : '0;
                else             shift_q <= frame_right_q;
            end else if (slot_k <= DataW) begin
                sdata_q <= shift_q[DATA_W-1];
                shift_q <= shift_q << 1;
            end else begin
                sdata_q <= 1'b0;
            end
        end
    end

    // Holding register occupancy: a frame start drains it, a handshake fills it
    always_comb begin
        hold_full_d = hold_full_q;
        if (frame_start && hold_full_q) hold_full_d = 1'b0;
        else if (accept)                hold_full_d = 1'b1;
    end

    // Holding register, ready flag and underflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            underflow_q  <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            s_ready_q   <= !hold_full_d;
            underflow_q <= frame_start && !hold_full_q;
            if (accept) begin
                hold_left_q  <= s_left;
                hold_right_q <= s_right;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_controller.sv
// Directed bench for i2s_tx_controller: frame contents from a vector table,
// plus timed sequences for back-pressure, boundary handshake, stop and reset.
module tb_i2s_tx_controller;

    localparam int DATA_W    = 24;
    localparam int SLOT_W    = 32;
    localparam int BCLK_DIV  = 8;
    localparam int FRAME_CLK = 4 * SLOT_W * BCLK_DIV;  // 1024
    localparam int BCLK_PER  = 2 * BCLK_DIV;           // 16
    localparam int NFRAMES   = 9;

    logic              clk, rst_n, enable, s_valid, s_ready;
    logic [DATA_W-1:0] s_left, s_right;
    logic              bclk, lrclk, sdata, busy, underflow;

    i2s_tx_controller #(
        .DATA_W  (DATA_W),
        .SLOT_W  (SLOT_W),
        .BCLK_DIV(BCLK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .busy     (busy),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [63:0] exp;   // {0, left, 7'b0, 0, right, 7'b0} as sent on the wire
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] exp_frames[NFRAMES];

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor state
    int   cyc = 0;
    logic cap_sd[0:1023];
    logic cap_lr[0:1023];
    int   cap_n = 0;
    int   uf_pulses = 0;
    logic prev_bclk = 1'b0, prev_lr = 1'b1, prev_uf = 1'b0;
    bit   armed = 0, rise_ok = 0, lrf_ok = 0;
    int   last_rise = 0, last_lrf = 0, fall_cnt = 0;

    // Sample on the inactive edge: capture bits on bclk rises, check clock ratios
    always @(negedge clk) begin
        logic bfall, brise;
        cyc++;
        bfall = prev_bclk && !bclk;
        brise = !prev_bclk && bclk;
        if (!busy) begin
            armed = 0; rise_ok = 0; lrf_ok = 0; fall_cnt = 0;
        end else begin
            if (bfall) begin
                armed = 1;
                fall_cnt++;
            end
            if (brise) begin
                if (rise_ok) check((cyc - last_rise) == BCLK_PER, "bclk_period",
                                   cyc - last_rise, BCLK_PER);
                last_rise = cyc;
                rise_ok   = 1;
                if (armed && cap_n < 1024) begin
                    cap_sd[cap_n] = sdata;
                    cap_lr[cap_n] = lrclk;
                    cap_n++;
                end
            end
            if (lrclk != prev_lr) check(bfall, "lrclk_edge_on_bclk_fall", bfall, 1);
            if (prev_lr && !lrclk) begin
                if (lrf_ok) begin
                    check((cyc - last_lrf) == FRAME_CLK, "lrclk_period", cyc - last_lrf,
                          FRAME_CLK);
                    check(fall_cnt == 2 * SLOT_W, "falls_per_frame", fall_cnt, 2 * SLOT_W);
                end
                last_lrf = cyc;
                lrf_ok   = 1;
                fall_cnt = 0;
            end
        end
        if (underflow && prev_uf) check(0, "underflow_width", 2, 1);
        if (underflow && !prev_uf) uf_pulses++;
        prev_bclk = bclk;
        prev_lr   = lrclk;
        prev_uf   = underflow;
    end

    task automatic push_pair(input int i);
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(s_ready, "push_ready_timeout", s_ready, 1);
        s_valid = 1'b1;
        s_left  = vecs[i].left;
        s_right = vecs[i].right;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_lr_fall();
        logic p = lrclk;
        int   n = 0;
        bit   seen = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (p && !lrclk) seen = 1;
            p = lrclk;
        end
        check(seen, "lrclk_fall_timeout", seen, 1);
    endtask

    task automatic wait_bits(input int want);
        int n = 0;
        while (cap_n < want && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(cap_n >= want, "bit_capture_timeout", cap_n, want);
    endtask

    initial begin
        int idx, n, falls;
        longint last_t, acc_t;
        logic p;
        logic [63:0] act_sd, act_lr;

        vecs[0] = '{24'hABCDEF, 24'h123456, 64'h55E6F780_091A2B00};
        vecs[1] = '{24'hFFFFFF, 24'h000001, 64'h7FFFFF80_00000080};
        vecs[2] = '{24'h800000, 24'h7FFFFF, 64'h40000000_3FFFFF80};
        vecs[3] = '{24'h5A5A5A, 24'hA5A5A5, 64'h2D2D2D00_52D2D280};
        vecs[4] = '{24'h000001, 24'h800000, 64'h00000080_40000000};
        vecs[5] = '{24'hC0FFEE, 24'h0BEEF0, 64'h607FF700_05F77800};
        vecs[6] = '{24'h13579B, 24'h2468AC, 64'h09ABCD80_12345600};
        for (int i = 0; i < 5; i++) exp_frames[i] = vecs[i].exp;
        exp_frames[5] = 64'h0;            // underflow frame
        exp_frames[6] = vecs[5].exp;      // pair handed over on the underflow boundary
        exp_frames[7] = 64'h0;            // second underflow, stop requested inside
        exp_frames[8] = vecs[6].exp;      // retained pair after restart

        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (3) @(negedge clk);
        check(bclk == 1'b0, "rst_bclk", bclk, 0);
        check(lrclk == 1'b1, "rst_lrclk", lrclk, 1);
        check(sdata == 1'b0, "rst_sdata", sdata, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(s_ready == 1'b0, "rst_s_ready", s_ready, 0);
        check(underflow == 1'b0, "rst_underflow", underflow, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check(s_ready == 1'b1, "s_ready_after_release", s_ready, 1);

        // Prefill while idle
        push_pair(0);
        check(s_ready == 1'b0, "prefill_s_ready_low", s_ready, 0);
        @(negedge clk);
        check(busy == 1'b0, "prefill_still_idle", busy, 0);
        check(lrclk == 1'b1, "idle_lrclk", lrclk, 1);
        enable = 1'b1;
        @(posedge clk);
        #1 check(busy == 1'b1, "enter_run", busy, 1);

        // Back-pressure: s_valid held high, one accept per frame
        s_valid = 1'b1; s_left = vecs[1].left; s_right = vecs[1].right;
        idx = 1; n = 0; last_t = 0;
        while (idx < 5 && n < 6000) begin
            @(negedge clk);
            n++;
            if (s_ready) begin
                acc_t = $time;
                if (idx > 1) check((acc_t - last_t) == FRAME_CLK * 10, "accept_spacing",
                                   acc_t - last_t, FRAME_CLK * 10);
                last_t = acc_t;
                @(posedge clk);
                #1 idx++;
                if (idx < 5) begin
                    s_left  = vecs[idx].left;
                    s_right = vecs[idx].right;
                end
            end
        end
        s_valid = 1'b0;
        check(idx == 5, "backpressure_accepts", idx, 5);

        // Handshake exactly on the boundary that finds holding empty
        wait_lr_fall();
        check(uf_pulses == 0, "no_underflow_yet", uf_pulses, 0);
        repeat (FRAME_CLK - 1) @(posedge clk);
        @(negedge clk);
        check(s_ready == 1'b1, "ready_before_boundary", s_ready, 1);
        s_valid = 1'b1; s_left = vecs[5].left; s_right = vecs[5].right;
        @(posedge clk);
        #1 s_valid = 1'b0;
        check(underflow == 1'b1, "underflow_on_boundary", underflow, 1);
        check(s_ready == 1'b0, "pair_stored_on_boundary", s_ready, 0);

        wait_lr_fall();
        check(uf_pulses == 1, "one_underflow", uf_pulses, 1);
        wait_lr_fall();

        // Graceful stop: pair arrives, enable drops at bit_cnt=10
        push_pair(6);
        check(uf_pulses == 2, "second_underflow", uf_pulses, 2);
        p = bclk; falls = 0; n = 0;
        while (falls < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (p && !bclk) falls++;
            p = bclk;
        end
        enable = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(!busy, "stop_reached_idle", busy, 0);
        check(cap_n == 8 * 64, "stop_after_full_frame", cap_n, 8 * 64);
        check(bclk == 1'b0, "stop_bclk", bclk, 0);
        check(lrclk == 1'b1, "stop_lrclk", lrclk, 1);
        check(s_ready == 1'b0, "stop_holding_retained", s_ready, 0);
        repeat (40) @(negedge clk);
        check(uf_pulses == 2, "stop_no_underflow", uf_pulses, 2);
        check(busy == 1'b0, "stays_idle", busy, 0);

        enable = 1'b1;
        wait_bits(NFRAMES * 64);

        // Frame contents table
        for (int f = 0; f < NFRAMES; f++) begin
            for (int j = 0; j < 64; j++) begin
                act_sd[63-j] = cap_sd[f*64+j];
                act_lr[63-j] = cap_lr[f*64+j];
            end
            check(act_sd == exp_frames[f], $sformatf("frame%0d_data", f), act_sd,
                  exp_frames[f]);
            check(act_lr == 64'h00000000_FFFFFFFF, $sformatf("frame%0d_lrclk", f), act_lr,
                  64'h00000000_FFFFFFFF);
        end

        // Mid-frame asynchronous reset
        n = 0;
        while (!(bclk && !lrclk) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(uf_pulses == 3, "underflow_after_restart", uf_pulses, 3);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check(bclk == 1'b0, "midrst_bclk", bclk, 0);
        check(lrclk == 1'b1, "midrst_lrclk", lrclk, 1);
        check(sdata == 1'b0, "midrst_sdata", sdata, 0);
        check(busy == 1'b0, "midrst_busy", busy, 0);
        check(s_ready == 1'b0, "midrst_s_ready", s_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check(s_ready == 1'b0, "midrst_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1 check(s_ready == 1'b1, "midrst_ready_after_edge", s_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx_controller.md
Name: i2s_tx_controller

Overview:
Sequences the I2S transmit path for the codec link. It derives BCLK and LRCLK from one system-clock divider chain, so LRCLK is always an exact multiple of BCLK. It accepts stereo sample pairs over a valid/ready handshake and serializes them MSB-first in standard I2S framing, with one BCLK of delay after each LRCLK edge. It sits between the DSP output stage and the codec pins, and flags underflow when the DSP misses a frame.

Parameters:
DATA_W, 24, sample width per channel; must satisfy DATA_W <= SLOT_W-1
SLOT_W, 32, BCLK periods per channel slot
BCLK_DIV, 8, clk cycles per BCLK half-period (>=2); frame = 4*SLOT_W*BCLK_DIV clk cycles

Ports:
clk  in  1  system clock, 50 MHz; all logic on posedge
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run link, 0 = stop at next frame boundary
s_valid  in  1  sample pair valid
s_ready  out  1  holding register empty, pair accepted when s_valid&&s_ready
s_left  in  DATA_W  left sample, two's complement
s_right  in  DATA_W  right sample, two's complement
bclk  out  1  I2S bit clock
lrclk  out  1  I2S word select; 0 = left, 1 = right
sdata  out  1  I2S serial data, changes only on bclk falling edges
busy  out  1  1 while in RUN
underflow  out  1  one-clk pulse when a frame starts with no sample pair held

Behaviour:
- Reset (async, rst_n=0) forces: bclk=0, lrclk=1, sdata=0, busy=0, underflow=0, s_ready=0, holding empty, state=IDLE, div_cnt=0, bit_cnt=0. s_ready=1 from the first clk after rst_n deasserts.
- Reset mid-frame aborts the frame immediately; no tail bits are sent.
- States: IDLE, RUN.
- IDLE:
  - bclk=0, lrclk=1, sdata=0.
  - Counters are held at 0.
  - Holding register still accepts one pair (prefill).
  - enable=1 moves to RUN on the next clk.
- RUN, clock generation:
  - div_cnt counts 0..BCLK_DIV-1; on reaching BCLK_DIV-1 it wraps and bclk toggles.
  - A falling event is a toggle where bclk is currently 1.
  - The first falling event occurs 2*BCLK_DIV clk cycles after entering RUN.
- RUN, each falling event:
  - bit_cnt advances modulo 2*SLOT_W. The first event after entering RUN sets bit_cnt=0.
  - lrclk = (bit_cnt >= SLOT_W), registered on the same clk as the bclk fall.
  - Slot position k = bit_cnt mod SLOT_W.
  - sdata = 0 for k=0 (I2S delay bit) and for k>DATA_W. For 1<=k<=DATA_W, sdata = channel bit DATA_W-k.
- Frame boundary = falling event at which bit_cnt becomes 0:
  - Holding full: the pair moves to the shift/frame register and the holding register empties, so s_ready=1 on the next clk.
  - Holding empty: the frame register is loaded with zeros and underflow pulses high for exactly one clk.
- Handshake:
  - s_ready = !holding_full, registered.
  - Data is captured on the clk where s_valid&&s_ready; s_ready drops on the next clk.
  - s_valid with s_ready=0 is ignored; the source must hold it.
- Simultaneous events:
  - A handshake on the same clk as a frame boundary with holding empty still counts as underflow. The new pair is stored for the following frame.
  - A handshake on a boundary where holding is full cannot occur (s_ready=0).
- enable=0 in RUN:
  - The current frame completes, including the right slot.
  - At the next frame boundary the block enters IDLE instead of starting a frame; no underflow is raised.
  - The holding contents are retained.
- enable re-asserted before that boundary cancels the stop.
- busy = (state==RUN).
- bit_cnt width = clog2(2*SLOT_W); div_cnt width = clog2(BCLK_DIV). No other arithmetic is performed.

Test Plan:
- Reset values: assert rst_n=0 mid-run -> same clk edge gives bclk=0, lrclk=1, sdata=0, busy=0; s_ready=1 one clk after release.
- Clock ratios (defaults), enable=1 for 3 frames -> bclk period 16 clk, lrclk period 1024 clk, exactly 64 bclk falls per lrclk period, lrclk edges coincide with bclk falls.
- Serialization: prefill L=24'hABCDEF, R=24'h123456, then enable -> on bclk rising edges capture 0 then 101010111100110111101111 then 7 zeros for the left slot (lrclk=0), and the same pattern with 24'h123456 for the right slot.
- Underflow: no sample held at the 2nd frame boundary -> underflow high 1 clk, 64 zero bits sent; a pair supplied on that same boundary clk appears in the 3rd frame.
- Back-pressure: s_valid held high continuously -> exactly one accept per frame, s_ready low between boundaries, no sample lost or duplicated over 5 frames with incrementing data.
- Graceful stop: drop enable at bit_cnt=10 -> frame completes, IDLE entered at the boundary (bclk=0, lrclk=1, busy=0), no underflow pulse; re-enable restarts with a left slot.
